lcd_bus_arbiter: RTL and testbench
==================================

Name: lcd_bus_arbiter

Overview:
- Shares the single HD44780 LCD (4-bit interface) between two byte-level requesters: requester 0 = time display sequencer, requester 1 = settings/menu sequencer.
- Arbitrates, then serialises each granted byte into two E-strobed nibbles with fixed setup/pulse/hold timing.
- Holds off the bus for the controller execution time, using the long wait for clear/home.
- Sits between the display sequencers and the LCD pins.

Parameters:
- T_SU, 2, cycles RS/D stable before E rises
- T_EH, 12, cycles E held high per nibble
- T_HOLD, 2, cycles RS/D held after E falls
- T_NIB, 2, idle cycles between upper and lower nibble
- T_EXEC, 2000, post-byte wait for normal commands/data (40 us at 50 MHz)
- T_LONG, 80000, post-byte wait for clear/home (1.6 ms at 50 MHz)
- CW, 17, wait counter width; must hold max(T_LONG, T_EXEC)

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_req0  in  1  requester 0 byte request; held until o_ack0
- i_rs0  in  1  requester 0 register select (0 cmd, 1 data)
- i_byte0  in  8  requester 0 byte
- i_lock0  in  1  requester 0 keeps grant after current byte
- o_ack0  out  1  one-cycle pulse: requester 0 byte captured
- i_req1, i_rs1, i_byte1[7:0], i_lock1, o_ack1: same for requester 1
- o_lcd_rs  out  1  LCD RS
- o_lcd_e  out  1  LCD E
- o_lcd_d  out  4  LCD D7..D4
- o_busy  out  1  high whenever state != IDLE
- o_owner  out  1  requester of the current/last granted byte

Behaviour:
- Reset (async, immediate, mid-transfer included):
  - state = IDLE; all outputs 0; last_served = 1, so requester 0 wins first; lock cleared.
  - An interrupted byte is dropped and is not re-sent.
- All outputs are registered.
- States: IDLE, SU_H, EH_H, HD_H, GAP, SU_L, EH_L, HD_L, EXEC. A CW-bit down-counter times each state.
- IDLE, eligible requester:
  - Eligibility:
    - If locked, only the owner is eligible. The arbiter waits indefinitely for the owner's request; the other requester stalls.
    - Otherwise a single requester wins.
    - If both request, the one != last_served wins (round-robin).
  - On the capturing edge:
    - latch rs/byte;
    - o_ackN = 1 for exactly one cycle;
    - o_owner = N; last_served = N;
    - o_lcd_rs = rs, o_lcd_d = byte[7:4];
    - go to SU_H.
- Nibble and wait sequence:
  - SU_H: T_SU cycles, E = 0.
  - EH_H: T_EH cycles, E = 1.
  - HD_H: T_HOLD cycles, E = 0, data held.
  - GAP: T_NIB cycles. o_lcd_d switches to byte[3:0] on entry to SU_L.
  - SU_L / EH_L / HD_L: same timing as the upper nibble.
  - EXEC: T_LONG if rs = 0 and byte[7:2] = 0 (0x01, 0x02, 0x03); else T_EXEC. Then IDLE.
- RS and D are stable from SU_H entry to HD_L exit, apart from the nibble swap at SU_L entry. E never changes in the same cycle as RS/D.
- Lock:
  - Sampled from the owner on the EXEC-to-IDLE edge; lock = i_lockN.
  - A locked requester may send back-to-back bytes with no interleaving.
  - Lock releases when the owner's lock is low at the end of a byte.
- Requests during a transfer are not acked; they are evaluated in IDLE.
- A requester still asserting i_req in IDLE after its ack is treated as a new byte; requesters must drop i_req on ack.
- Per-byte latency, IDLE capture to return to IDLE:
  - 1 + 2*(T_SU+T_EH+T_HOLD) + T_NIB + exec cycles.
  - With defaults: 35 + 2000 for a normal byte; 35 + 80000 for clear/home.
- Byte and RS inputs are sampled only at capture. Changes after ack have no effect.

Test Plan:
- Reset then req0 with rs=1, byte=0x4B -> o_ack0 one cycle, o_owner=0; D=0x4 with E high exactly 12 cycles; then D=0xB with E high 12 cycles; RS=1 throughout; o_busy low 2035 cycles after capture.
- req1 with rs=0, byte=0x01 -> E pulses as above, RS=0; o_busy held for EXEC = 80000 cycles; byte 0x04 with rs=0 uses 2000.
- req0 and req1 both asserted from reset -> requester 0 served first, then requester 1, then requester 0 again (alternating), with every ack pulse single-cycle.
- req0 with i_lock0=1 for three bytes while req1 is continuously asserted -> all three req0 bytes complete before o_ack1. Drop i_lock0 with the third byte -> req1 is granted next.
- Assert i_reset mid-EH_H -> o_lcd_e, o_lcd_d and o_busy go to 0 without waiting for a clock edge. After release, a pending req0 restarts cleanly from SU_H.
- Change i_byte0 from 0x4B to 0xFF the cycle after ack -> the LCD still sees nibbles 0x4 and 0xB.

Source files
------------

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: shares one HD44780 LCD (4-bit mode) between two byte
// requesters. Each granted byte goes out as two E-strobed nibbles, then the
// bus is held off for the controller execution time.
module lcd_bus_arbiter #(
  parameter int T_SU   = 2,
  parameter int T_EH   = 12,
  parameter int T_HOLD = 2,
  parameter int T_NIB  = 2,
  parameter int T_EXEC = 2000,
  parameter int T_LONG = 80000,
  parameter int CW     = 17
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req0,
  input  logic       i_rs0,
  input  logic [7:0] i_byte0,
  input  logic       i_lock0,
  output logic       o_ack0,
  input  logic       i_req1,
  input  logic       i_rs1,
  input  logic [7:0] i_byte1,
  input  logic       i_lock1,
  output logic       o_ack1,
  output logic       o_lcd_rs,
  output logic       o_lcd_e,
  output logic [3:0] o_lcd_d,
  output logic       o_busy,
  output logic       o_owner
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_SU_H = 4'd1;
  localparam logic [3:0] S_EH_H = 4'd2;
  localparam logic [3:0] S_HD_H = 4'd3;
  localparam logic [3:0] S_GAP  = 4'd4;
  localparam logic [3:0] S_SU_L = 4'd5;
  localparam logic [3:0] S_EH_L = 4'd6;
  localparam logic [3:0] S_HD_L = 4'd7;
  localparam logic [3:0] S_EXEC = 4'd8;

  // Counter reloads are "cycles - 1" so a state lasts exactly its cycle
  // count. EXEC loads the full wait, giving one extra turnaround cycle so
  // capture-to-IDLE spans 1 + 2*(T_SU+T_EH+T_HOLD) + T_NIB + wait.
  localparam logic [CW-1:0] C_SU   = CW'(T_SU - 1);
  localparam logic [CW-1:0] C_EH   = CW'(T_EH - 1);
  localparam logic [CW-1:0] C_HOLD = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] C_NIB  = CW'(T_NIB - 1);
  localparam logic [CW-1:0] C_EXEC = CW'(T_EXEC);
  localparam logic [CW-1:0] C_LONG = CW'(T_LONG);

  logic [3:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_ack0, r_ack1;
  logic          r_lcd_rs, r_lcd_e, r_busy, r_owner;
  logic [3:0]    r_lcd_d;
  logic          r_last;
  logic          r_lock;
  logic          r_rs;
  logic [7:0]    r_byte;

  logic          w_grant, w_sel, w_rs, w_long, w_done;
  logic [7:0]    w_byte;

  // Arbitration: a held lock admits only the owner, otherwise round-robin.
  always_comb begin
    w_grant = 1'b0;
    w_sel   = 1'b0;
    if (r_lock) begin
      w_sel   = r_owner;
      w_grant = r_owner ? i_req1 : i_req0;
    end else if (i_req0 && i_req1) begin
      w_sel   = ~r_last;
      w_grant = 1'b1;
    end else begin
      w_sel   = i_req1;
      w_grant = i_req0 | i_req1;
    end
  end

  assign w_rs   = w_sel ? i_rs1 : i_rs0;
  assign w_byte = w_sel ? i_byte1 : i_byte0;
  // Clear/home (and 0x00-0x03 in general) need the long execution wait.
  assign w_long = ~r_rs && (r_byte[7:2] == 6'd0);
  assign w_done = (r_cnt == '0);

  // Captured byte and RS; only ever read while a transfer is in flight.
  always_ff @(posedge i_clk) begin
    if (r_state == S_IDLE && w_grant) begin
      r_rs   <= w_rs;
      r_byte <= w_byte;
    end
  end

  // Control FSM, timing counter and registered LCD pins.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_lcd_rs <= 1'b0;
      r_lcd_e  <= 1'b0;
      r_lcd_d  <= 4'd0;
      r_busy   <= 1'b0;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_lock   <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      if (!w_done) r_cnt <= r_cnt - CW'(1);
      case (r_state)
        S_IDLE: if (w_grant) begin
          r_lcd_rs <= w_rs;
          r_lcd_d  <= w_byte[7:4];
          r_owner  <= w_sel;
          r_last   <= w_sel;
          r_ack0   <= ~w_sel;
          r_ack1   <= w_sel;
          r_busy   <= 1'b1;
          r_cnt    <= C_SU;
          r_state  <= S_SU_H;
        end
        S_SU_H: if (w_done) begin
          r_lcd_e <= 1'b1;
          r_cnt   <= C_EH;
          r_state <= S_EH_H;
        end
        S_EH_H: if (w_done) begin
          r_lcd_e <= 1'b0;
          r_cnt   <= C_HOLD;
          r_state <= S_HD_H;
        end
        S_HD_H: if (w_done) begin
          r_cnt   <= C_NIB;
          r_state <= S_GAP;
        end
        S_GAP: if (w_done) begin
          r_lcd_d <= r_byte[3:0];
          r_cnt   <= C_SU;
          r_state <= S_SU_L;
        end
        S_SU_L: if (w_done) begin
          r_lcd_e <= 1'b1;
          r_cnt   <= C_EH;
          r_state <= S_EH_L;
        end
        S_EH_L: if (w_done) begin
          r_lcd_e <= 1'b0;
          r_cnt   <= C_HOLD;
          r_state <= S_HD_L;
        end
        S_HD_L: if (w_done) begin
          r_cnt   <= w_long ? C_LONG : C_EXEC;
          r_state <= S_EXEC;
        end
        S_EXEC: if (w_done) begin
          r_lock  <= r_owner ? i_lock1 : i_lock0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_lcd_e <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ack0   = r_ack0;
  assign o_ack1   = r_ack1;
  assign o_lcd_rs = r_lcd_rs;
  assign o_lcd_e  = r_lcd_e;
  assign o_lcd_d  = r_lcd_d;
  assign o_busy   = r_busy;
  assign o_owner  = r_owner;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter: nibble timing, execution waits,
// round-robin, lock, async reset and capture-only sampling.
module tb_lcd_bus_arbiter;

  localparam int TE = 100;
  localparam int TL = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, rs0 = 1'b0, lock0 = 1'b0;
  logic       req1 = 1'b0, rs1 = 1'b0, lock1 = 1'b0;
  logic [7:0] byte0 = 8'h00, byte1 = 8'h00;
  logic       ack0, ack1, lcd_rs, lcd_e, busy, owner;
  logic [3:0] lcd_d;

  int total = 0;
  int bad   = 0;

  lcd_bus_arbiter #(.T_EXEC(TE), .T_LONG(TL)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req0(req0), .i_rs0(rs0), .i_byte0(byte0), .i_lock0(lock0), .o_ack0(ack0),
    .i_req1(req1), .i_rs1(rs1), .i_byte1(byte1), .i_lock1(lock1), .o_ack1(ack1),
    .o_lcd_rs(lcd_rs), .o_lcd_e(lcd_e), .o_lcd_d(lcd_d),
    .o_busy(busy), .o_owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for the next grant and follows the whole byte cycle by cycle.
  // Index 0 is the negedge after the capture edge; the byte ends (busy low)
  // at index 35+ex. After ack the owner drops its request and scrambles its
  // byte/RS; at index 2 it sets its lock and optionally presents a new byte.
  task automatic run_byte(input logic own, input logic ers, input logic [3:0] hi,
                          input logic [3:0] lo, input int ex, input logic lk,
                          input logic nreq, input logic nrs, input logic [7:0] nbyte);
    bit got = 0;
    int e_err = 0, d_err = 0, rs_err = 0, ack_err = 0, busy_err = 0;
    int last = 35 + ex;
    logic exp_e;
    logic [3:0] exp_d;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (ack0 | ack1) got = 1;
    end
    chk("ack_who", 32'({ack1, ack0}), own ? 32'd2 : 32'd1);
    chk("owner", 32'(owner), 32'(own));
    chk("busy_on", 32'(busy), 32'd1);
    chk("rs_setup", 32'(lcd_rs), 32'(ers));
    chk("d_setup", 32'(lcd_d), 32'(hi));
    chk("e_setup", 32'(lcd_e), 32'd0);
    if (own) begin req1 = 1'b0; byte1 = 8'hFF; rs1 = ~rs1; end
    else     begin req0 = 1'b0; byte0 = 8'hFF; rs0 = ~rs0; end
    for (int i = 1; i <= last; i++) begin
      @(negedge clk);
      if (i == 2) begin
        if (own) lock1 = lk; else lock0 = lk;
        if (nreq) begin
          if (own) begin req1 = 1'b1; rs1 = nrs; byte1 = nbyte; end
          else     begin req0 = 1'b1; rs0 = nrs; byte0 = nbyte; end
        end
      end
      exp_e = ((i >= 2) && (i <= 13)) || ((i >= 20) && (i <= 31));
      exp_d = (i < 18) ? hi : lo;
      if (lcd_e !== exp_e) e_err++;
      if (i <= 33 && lcd_d !== exp_d) d_err++;
      if (i <= 33 && lcd_rs !== ers) rs_err++;
      if (ack0 | ack1) ack_err++;
      if (busy !== (i < last)) busy_err++;
    end
    chk("e_pattern", 32'(e_err), 32'd0);
    chk("d_pattern", 32'(d_err), 32'd0);
    chk("rs_stable", 32'(rs_err), 32'd0);
    chk("ack_single", 32'(ack_err), 32'd0);
    chk("busy_len", 32'(busy_err), 32'd0);
  endtask

  initial begin
    bit got;
    // Reset state
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'({ack1, ack0}), 32'd0);
    chk("rst_e", 32'(lcd_e), 32'd0);
    chk("rst_d", 32'(lcd_d), 32'd0);
    chk("rst_rs", 32'(lcd_rs), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    rst = 1'b0;

    // Data byte 0x4B from requester 0; inputs scrambled right after ack
    rs0 = 1'b1; byte0 = 8'h4B; req0 = 1'b1;
    run_byte(1'b0, 1'b1, 4'h4, 4'hB, TE, 1'b0, 1'b0, 1'b0, 8'h00);

    // Clear (long wait) then a normal command from requester 1
    rs1 = 1'b0; byte1 = 8'h01; req1 = 1'b1;
    run_byte(1'b1, 1'b0, 4'h0, 4'h1, TL, 1'b0, 1'b0, 1'b0, 8'h00);
    rs1 = 1'b0; byte1 = 8'h04; req1 = 1'b1;
    run_byte(1'b1, 1'b0, 4'h0, 4'h4, TE, 1'b0, 1'b0, 1'b0, 8'h00);

    // Both requesting from reset: 0, 1, 0
    @(negedge clk) rst = 1'b1;
    rs0 = 1'b1; byte0 = 8'h30; req0 = 1'b1;
    rs1 = 1'b1; byte1 = 8'h31; req1 = 1'b1;
    @(negedge clk) rst = 1'b0;
    run_byte(1'b0, 1'b1, 4'h3, 4'h0, TE, 1'b0, 1'b1, 1'b1, 8'h32);
    run_byte(1'b1, 1'b1, 4'h3, 4'h1, TE, 1'b0, 1'b0, 1'b0, 8'h00);
    run_byte(1'b0, 1'b1, 4'h3, 4'h2, TE, 1'b0, 1'b0, 1'b0, 8'h00);

    // Locked burst of three bytes from requester 0 with requester 1 waiting
    @(negedge clk) rst = 1'b1;
    rs1 = 1'b1; byte1 = 8'h51; req1 = 1'b1;
    rs0 = 1'b1; byte0 = 8'h41; req0 = 1'b1; lock0 = 1'b1;
    @(negedge clk) rst = 1'b0;
    run_byte(1'b0, 1'b1, 4'h4, 4'h1, TE, 1'b1, 1'b1, 1'b1, 8'h42);
    run_byte(1'b0, 1'b1, 4'h4, 4'h2, TE, 1'b1, 1'b1, 1'b1, 8'h43);
    run_byte(1'b0, 1'b1, 4'h4, 4'h3, TE, 1'b0, 1'b0, 1'b0, 8'h00);
    run_byte(1'b1, 1'b1, 4'h5, 4'h1, TE, 1'b0, 1'b0, 1'b0, 8'h00);

    // Asynchronous reset in the middle of the upper E pulse
    rs0 = 1'b1; byte0 = 8'h4B; req0 = 1'b1;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (ack0) got = 1;
    end
    chk("mid_ack", 32'(got), 32'd1);
    repeat (4) @(negedge clk);
    chk("mid_e_high", 32'(lcd_e), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_e", 32'(lcd_e), 32'd0);
    chk("arst_d", 32'(lcd_d), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rs", 32'(lcd_rs), 32'd0);
    @(negedge clk) rst = 1'b0;
    run_byte(1'b0, 1'b1, 4'h4, 4'hB, TE, 1'b0, 1'b0, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
